// File: rtl/dmem_stall_resp_if.sv
// Request/response bundle between the M-stage and the data-memory responder.
// The pipeline side is the master; the responder that produces stallM is the slave.
interface dmem_stall_resp_if;
    logic        req_valid;
    logic        req_write;
    logic [63:0] req_addr;
    logic [2:0]  req_size;
    logic [7:0]  req_strobe;
    logic [63:0] req_wdata;
    logic        stallM;
    logic        resp_data_ok;
    logic [63:0] resp_rdata;
    logic        err_misalign;

    modport master (
        output req_valid, req_write, req_addr, req_size, req_strobe, req_wdata,
        input  stallM, resp_data_ok, resp_rdata, err_misalign
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_size, req_strobe, req_wdata,
        output stallM, resp_data_ok, resp_rdata, err_misalign
    );
endinterface

// File: rtl/dmem_stall_resp.sv
// Fixed-latency data-memory responder: holds the pipeline with stallM while one
// load/store is outstanding, then commits it to a word-addressed store.
module dmem_stall_resp #(
    parameter int LAT   = 2,
    parameter int DEPTH = 256,
    localparam int AW   = $clog2(DEPTH)
) (
    input logic            clk,
    input logic            reset,
    dmem_stall_resp_if.slave bus
);

    if (LAT < 1) begin : gLatCheck
        $error("dmem_stall_resp: LAT must be at least 1");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : gDepthCheck
        $error("dmem_stall_resp: DEPTH must be a power of two");
    end

    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(LAT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   counter;
    logic            latWrite;
    logic            latBad;
    logic [AW-1:0]   latIndex;
    logic [7:0]      latStrobe;
    logic [63:0]     latWdata;
    logic [2:0]      alignMask;
    logic            reqBad;
    logic            commit;
    logic            unusedAddr;
    logic [63:0]     store [DEPTH];

    // Alignment is judged once, at acceptance, so only the verdict is latched.
    always_comb begin
        case (bus.req_size)
            3'd0:    alignMask = 3'b000;
            3'd1:    alignMask = 3'b001;
            3'd2:    alignMask = 3'b011;
            3'd3:    alignMask = 3'b111;
            default: alignMask = 3'b000;
        endcase
        reqBad = (bus.req_size > 3'd3) || ((bus.req_addr[2:0] & alignMask) != 3'b000);
    end

    assign unusedAddr = &{1'b0, bus.req_addr[63:AW+3]};
    assign commit     = (state == BUSY) && (counter == '0);

    // Gating with reset makes the stall disappear the moment reset asserts,
    // even if the pipeline is still presenting a request.
    assign bus.stallM = reset && (((state == IDLE) && bus.req_valid) || (state == BUSY));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            counter          <= '0;
            latWrite         <= 1'b0;
            latBad           <= 1'b0;
            latIndex         <= '0;
            latStrobe        <= '0;
            latWdata         <= '0;
            bus.resp_data_ok <= 1'b0;
            bus.err_misalign <= 1'b0;
            bus.resp_rdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.resp_data_ok <= 1'b0;
                    bus.err_misalign <= 1'b0;
                    if (bus.req_valid) begin
                        latWrite  <= bus.req_write;
                        latBad    <= reqBad;
                        latIndex  <= bus.req_addr[AW+2:3];
                        latStrobe <= bus.req_strobe;
                        latWdata  <= bus.req_wdata;
                        counter   <= CNT_LOAD;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (counter != '0) begin
                        counter <= counter - 1'b1;
                    end else begin
                        state            <= DONE;
                        bus.resp_data_ok <= 1'b1;
                        bus.err_misalign <= latBad;
                        if (latBad) begin
                            bus.resp_rdata <= '0;
                        end else if (!latWrite) begin
                            bus.resp_rdata <= store[latIndex];
                        end
                    end
                end
                DONE: begin
                    bus.resp_data_ok <= 1'b0;
                    bus.err_misalign <= 1'b0;
                    state            <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Backing store is never reset; a low reset on the commit edge blocks the write.
    always_ff @(posedge clk) begin
        if (reset && commit && latWrite && !latBad) begin
            for (int i = 0; i < 8; i++) begin
                if (latStrobe[i]) begin
                    store[latIndex][8*i +: 8] <= latWdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_stall_resp.sv
// Directed bench for dmem_stall_resp: table of whole transactions on a LAT=2
// instance, plus hand sequences for back-to-back, reset-in-BUSY and LAT=1.
module tb_dmem_stall_resp;

    localparam int LAT = 2;

    typedef struct {
        logic        write;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] wdata;
        logic [63:0] expRdata;
        logic        expErr;
    } vec_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    vec_t vecs [14];

    dmem_stall_resp_if bus ();
    dmem_stall_resp_if bus1 ();

    dmem_stall_resp #(.LAT(LAT), .DEPTH(256)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    dmem_stall_resp #(.LAT(1), .DEPTH(256)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b, required %b", name, act, exp);
        end
    endtask

    // One full transaction on the LAT=2 instance, checking every cycle t..t+LAT+2.
    task automatic applyStimulus(input vec_t v, input string tag);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_write  = v.write;
        bus.req_addr   = v.addr;
        bus.req_size   = v.size;
        bus.req_strobe = v.strobe;
        bus.req_wdata  = v.wdata;
        #1;
        checkBit({tag, " stall t"}, bus.stallM, 1'b1);
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.req_valid  = 1'b0;
                bus.req_write  = 1'b1;
                bus.req_addr   = ~v.addr;
                bus.req_size   = 3'd3;
                bus.req_strobe = 8'hFF;
                bus.req_wdata  = ~v.wdata;
            end
            #1;
            checkBit({tag, " stall busy"}, bus.stallM, 1'b1);
            checkBit({tag, " ok busy"}, bus.resp_data_ok, 1'b0);
        end
        @(negedge clk);
        #1;
        checkBit({tag, " stall done"}, bus.stallM, 1'b0);
        checkBit({tag, " ok done"}, bus.resp_data_ok, 1'b1);
        checkBit({tag, " err done"}, bus.err_misalign, v.expErr);
        checkOutput({tag, " rdata done"}, bus.resp_rdata, v.expRdata);
        @(negedge clk);
        #1;
        checkBit({tag, " ok after"}, bus.resp_data_ok, 1'b0);
        checkBit({tag, " err after"}, bus.err_misalign, 1'b0);
        checkOutput({tag, " rdata held"}, bus.resp_rdata, v.expRdata);
    endtask

    task automatic applyLat1(input logic write, input logic [63:0] addr, input logic [63:0] wdata,
                             input logic [63:0] expRdata, input string tag);
        @(negedge clk);
        bus1.req_valid  = 1'b1;
        bus1.req_write  = write;
        bus1.req_addr   = addr;
        bus1.req_size   = 3'd3;
        bus1.req_strobe = 8'hFF;
        bus1.req_wdata  = wdata;
        #1;
        checkBit({tag, " stall t"}, bus1.stallM, 1'b1);
        @(negedge clk);
        bus1.req_valid = 1'b0;
        #1;
        checkBit({tag, " stall t+1"}, bus1.stallM, 1'b1);
        checkBit({tag, " ok t+1"}, bus1.resp_data_ok, 1'b0);
        @(negedge clk);
        #1;
        checkBit({tag, " stall t+2"}, bus1.stallM, 1'b0);
        checkBit({tag, " ok t+2"}, bus1.resp_data_ok, 1'b1);
        checkOutput({tag, " rdata t+2"}, bus1.resp_rdata, expRdata);
        @(negedge clk);
        #1;
        checkBit({tag, " ok t+3"}, bus1.resp_data_ok, 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        //            write addr           size  strobe  wdata                  expRdata               err
        vecs[0]  = '{1'b1, 64'h10,  3'd3, 8'hFF, 64'h1122334455667788, 64'h0,                 1'b0};
        vecs[1]  = '{1'b0, 64'h10,  3'd3, 8'h00, 64'h0,                 64'h1122334455667788, 1'b0};
        vecs[2]  = '{1'b1, 64'h11,  3'd0, 8'h02, 64'h000000000000AB00, 64'h1122334455667788, 1'b0};
        vecs[3]  = '{1'b0, 64'h10,  3'd3, 8'h00, 64'h0,                 64'h112233445566AB88, 1'b0};
        vecs[4]  = '{1'b0, 64'h12,  3'd2, 8'h00, 64'h0,                 64'h0,                 1'b1};
        vecs[5]  = '{1'b1, 64'h13,  3'd1, 8'hFF, 64'hFFFFFFFFFFFFFFFF, 64'h0,                 1'b1};
        vecs[6]  = '{1'b0, 64'h10,  3'd3, 8'h00, 64'h0,                 64'h112233445566AB88, 1'b0};
        vecs[7]  = '{1'b1, 64'h18,  3'd3, 8'hFF, 64'h0123456789ABCDEF, 64'h112233445566AB88, 1'b0};
        vecs[8]  = '{1'b1, 64'h1C,  3'd2, 8'hF0, 64'hDEADBEEF00000000, 64'h112233445566AB88, 1'b0};
        vecs[9]  = '{1'b0, 64'h18,  3'd3, 8'h00, 64'h0,                 64'hDEADBEEF89ABCDEF, 1'b0};
        vecs[10] = '{1'b0, 64'h10,  3'd5, 8'h00, 64'h0,                 64'h0,                 1'b1};
        vecs[11] = '{1'b1, 64'h16,  3'd1, 8'hC0, 64'h5A5A000000000000, 64'h0,                 1'b0};
        vecs[12] = '{1'b0, 64'h810, 3'd3, 8'h00, 64'h0,                 64'h5A5A33445566AB88, 1'b0};
        vecs[13] = '{1'b0, 64'h1F,  3'd0, 8'h00, 64'h0,                 64'hDEADBEEF89ABCDEF, 1'b0};

        bus.req_valid   = 1'b0;
        bus.req_write   = 1'b0;
        bus.req_addr    = '0;
        bus.req_size    = '0;
        bus.req_strobe  = '0;
        bus.req_wdata   = '0;
        bus1.req_valid  = 1'b0;
        bus1.req_write  = 1'b0;
        bus1.req_addr   = '0;
        bus1.req_size   = '0;
        bus1.req_strobe = '0;
        bus1.req_wdata  = '0;
        reset = 1'b1;
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checkBit("reset stall", bus.stallM, 1'b0);
        checkBit("reset ok", bus.resp_data_ok, 1'b0);
        checkBit("reset err", bus.err_misalign, 1'b0);
        checkOutput("reset rdata", bus.resp_rdata, 64'h0);
        checkBit("reset stall lat1", bus1.stallM, 1'b0);
        checkOutput("reset rdata lat1", bus1.resp_rdata, 64'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        checkBit("idle stall", bus.stallM, 1'b0);

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // Back-to-back: valid stays high through DONE; second request must wait for IDLE.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 64'h810;
        bus.req_size  = 3'd3;
        #1;
        checkBit("b2b stall t", bus.stallM, 1'b1);
        @(negedge clk);
        bus.req_addr = 64'h18;
        #1;
        checkBit("b2b stall t+1", bus.stallM, 1'b1);
        @(negedge clk);
        #1;
        checkBit("b2b stall t+2", bus.stallM, 1'b1);
        @(negedge clk);
        #1;
        checkBit("b2b stall done", bus.stallM, 1'b0);
        checkBit("b2b ok done", bus.resp_data_ok, 1'b1);
        checkOutput("b2b rdata first", bus.resp_rdata, 64'h5A5A33445566AB88);
        @(negedge clk);
        #1;
        checkBit("b2b stall accept", bus.stallM, 1'b1);
        checkBit("b2b ok accept", bus.resp_data_ok, 1'b0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        #1;
        checkBit("b2b stall t+5", bus.stallM, 1'b1);
        @(negedge clk);
        #1;
        checkBit("b2b stall t+6", bus.stallM, 1'b1);
        checkBit("b2b ok t+6", bus.resp_data_ok, 1'b0);
        @(negedge clk);
        #1;
        checkBit("b2b ok second", bus.resp_data_ok, 1'b1);
        checkOutput("b2b rdata second", bus.resp_rdata, 64'hDEADBEEF89ABCDEF);
        @(negedge clk);
        #1;
        checkBit("b2b ok after", bus.resp_data_ok, 1'b0);

        // LAT=1 instance: two-cycle stall, completion at t+2.
        applyLat1(1'b1, 64'h20, 64'hCAFEF00D12345678, 64'h0, "lat1 store");
        applyLat1(1'b0, 64'h20, 64'h0, 64'hCAFEF00D12345678, "lat1 load");

        // Reset in BUSY abandons a store of all ones to 0x10.
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b1;
        bus.req_addr   = 64'h10;
        bus.req_size   = 3'd3;
        bus.req_strobe = 8'hFF;
        bus.req_wdata  = 64'hFFFFFFFFFFFFFFFF;
        #1;
        checkBit("rst stall t", bus.stallM, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkBit("rst stall drop", bus.stallM, 1'b0);
        checkBit("rst ok", bus.resp_data_ok, 1'b0);
        checkOutput("rst rdata", bus.resp_rdata, 64'h0);
        bus.req_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            checkBit("rst ok held", bus.resp_data_ok, 1'b0);
        end
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            checkBit("post rst ok", bus.resp_data_ok, 1'b0);
            checkBit("post rst stall", bus.stallM, 1'b0);
        end
        applyStimulus('{1'b0, 64'h10, 3'd3, 8'h00, 64'h0, 64'h5A5A33445566AB88, 1'b0}, "post rst load");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_stall_resp.md
Name: dmem_stall_resp

Overview:
Memory-side responder for the M-stage data access. It is the producer of `stallM`, the signal the pipeline registers consume to hold their contents. It accepts one load/store request at a time from the memory stage and asserts `stallM` while the request is outstanding. After a fixed, parameterised latency it performs the access on an internal word-addressed backing store and pulses `resp_data_ok`.

Parameters:
- LAT, 2, cycles spent in BUSY per request; legal range ≥1; LAT=0 is a compile-time error.
- DEPTH, 256, number of 64-bit words in the backing store; must be a power of 2.
- AW, $clog2(DEPTH), word-index width; derived, not overridden.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  M-stage request present.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  64  byte address.
- req_size  in  3  0 = 1B, 1 = 2B, 2 = 4B, 3 = 8B; 4–7 illegal.
- req_strobe  in  8  byte-lane write enables, used for stores only.
- req_wdata  in  64  store data, lane-aligned.
- stallM  out  1  hold the pipeline registers.
- resp_data_ok  out  1  one-cycle completion pulse.
- resp_rdata  out  64  full load word.
- err_misalign  out  1  completion carried an alignment or size error; valid with resp_data_ok.

Behaviour:
- Reset (reset=0, takes effect immediately):
  - state = IDLE; stallM = 0, resp_data_ok = 0, err_misalign = 0, resp_rdata = 0; counter = 0.
  - Backing-store contents are not reset.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - req_valid=1 → latch write/addr/size/strobe/wdata; load counter with LAT-1; go to BUSY.
  - req_valid=0 → stay in IDLE.
- BUSY:
  - counter != 0 → decrement.
  - counter == 0 → commit the access at this edge and go to DONE.
- DONE:
  - resp_data_ok = 1 for exactly this cycle; go to IDLE unconditionally.
  - req_valid seen during DONE is not accepted, because the pipeline advances at this edge.
  - The next request is accepted in the following IDLE cycle.
- stallM (combinational) = (IDLE & req_valid) | BUSY; it is 0 in DONE.
- Timing for a request first presented in cycle t:
  - stallM high in cycles t .. t+LAT (LAT+1 cycles).
  - resp_data_ok high in cycle t+LAT+1.
  - Minimum request-to-request spacing is LAT+2 cycles.
- Word index = addr[AW+2:3]. Upper address bits are ignored, so addresses wrap modulo DEPTH*8 bytes.
- Misaligned condition: (size > 3) OR (addr[2:0] & ((1<<size)-1)) != 0.
  - No store or load is performed.
  - The request still completes normally through BUSY and DONE.
  - err_misalign = 1 and resp_rdata = 0 in the DONE cycle.
- Load commit: resp_rdata <= store[index], the full 64-bit word; byte extraction is the requester's job.
- Store commit:
  - For each lane i with strobe[i]=1, store[index][8i+7:8i] <= wdata[8i+7:8i].
  - Lanes with strobe=0 keep their old value.
  - resp_rdata keeps its previous value.
- resp_rdata is held stable until the next load commit, misaligned completion, or reset.
- err_misalign is 0 outside DONE cycles.
- Reset mid-operation:
  - Reset in BUSY abandons the request; the store is not written.
  - Reset coincident with the commit edge also suppresses the write.
  - stallM drops as soon as reset asserts.
- Request inputs are sampled only at the IDLE→BUSY edge. Changes while BUSY have no effect.

Test Plan:
- Store, LAT=2: addr 0x10, size 3, strobe 0xFF, wdata 0x1122334455667788, req_valid in cycle t.
  - Required: stallM = 1 in cycles t..t+2; resp_data_ok = 1 only in cycle t+3; err_misalign = 0.
- Load, aligned: addr 0x10, size 3.
  - Required: resp_rdata = 0x1122334455667788 with resp_data_ok, held afterwards while req_valid = 0.
- Byte store then load: store addr 0x11, size 0, strobe 0x02, wdata 0x000000000000AB00; then load 0x10.
  - Required: resp_rdata = 0x112233445566AB88.
- Misaligned access: load addr 0x12, size 2; then store addr 0x13, size 1.
  - Required for each: err_misalign = 1 and resp_data_ok in the same cycle; resp_rdata = 0; a following load of 0x10 is unchanged.
- Wrap and back-to-back: load addr 0x810 (= 0x10 + DEPTH*8) with req_valid held high across its DONE cycle and a second request following.
  - Required: returns the 0x10 word; the second request is accepted in cycle t+LAT+2, not in DONE; LAT=1 build gives stallM for exactly 2 cycles.
- Reset during BUSY: store addr 0x10, wdata all ones, reset pulled low in cycle t+1.
  - Required: stallM = 0 immediately; no resp_data_ok; a load of 0x10 after release returns the previous value.
